// File: rtl/stage_1_fetch_pkg.sv
// Shared types for the stage-1 fetch unit.
package stage_1_fetch_pkg;

    typedef logic [31:0] Addr;
    typedef logic [31:0] Data;
    typedef logic        Bool;

    // addi x0, x0, 0
    localparam Data NOP_INSTR = 32'h0000_0013;

    // One fetched word together with the address that follows it.
    typedef struct packed {
        Data instr;
        Addr pc;
    } FetchEntry;

endpackage

// File: rtl/stage_1_fetch_fetch_queue.sv
// In-order queue of fetched words between the memory response and decode.
module fetch_queue
    import stage_1_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  FetchEntry                  i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output FetchEntry                  o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    FetchEntry         r_mem [DEPTH];
    logic [PtrW-1:0]   r_rd_ptr;
    logic [PtrW-1:0]   r_wr_ptr;
    logic [CntW-1:0]   r_count;
    Bool               w_do_push;
    Bool               w_do_pop;

    // Flush wins over push and pop; a pop frees a slot for a same-cycle push.
    always_comb begin
        o_empty   = (r_count == '0);
        o_full    = (r_count == CntW'(DEPTH));
        w_do_pop  = i_pop && !o_empty && !i_flush;
        w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
        o_head    = r_mem[r_rd_ptr];
        o_count   = r_count;
    end

    // Pointer and occupancy state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            r_count <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
        end
    end

    // Entry storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // Issue credit upstream must make this unreachable.
    assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !i_flush && o_full && !i_pop));

endmodule

// File: rtl/stage_1_fetch.sv
// Pipeline stage 1: PC generation, instruction fetch and hand-off to decode.
module stage_1_fetch
    import stage_1_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH     = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_enable,
    input  logic [31:0] redirect_address,
    input  logic        stall_in,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

    Addr             r_fetch_pc;
    logic [OutW-1:0] r_outstanding;
    logic [OutW-1:0] r_discard;
    Data             r_instr;
    Addr             r_pc;
    Bool             r_valid;

    Bool             w_accept;
    Bool             w_drop;
    Bool             w_push;
    Bool             w_pop;
    Bool             w_q_empty;
    Bool             w_q_full;
    logic [CntW-1:0] w_q_count;
    FetchEntry       w_head;
    FetchEntry       w_push_entry;
    Addr             w_redirect_pc;

    // Issue credit, response routing and pop decision.
    always_comb begin
        imem_req_valid = !rst && !redirect_enable && !w_q_full
                         && (32'(r_outstanding) + 32'(w_q_count) < QUEUE_DEPTH)
                         && (32'(r_outstanding) < MAX_OUTSTANDING);
        imem_req_addr  = r_fetch_pc;
        w_accept       = imem_req_valid && imem_req_ready;
        w_redirect_pc  = redirect_address & 32'hFFFF_FFFC;
        w_drop         = (r_discard != '0);
        w_push         = imem_resp_valid && !w_drop && !redirect_enable;
        // With nothing left to discard, every outstanding request is live and
        // contiguous below fetch_pc, so the oldest one sits outstanding words back.
        w_push_entry.instr = imem_resp_data;
        w_push_entry.pc    = r_fetch_pc - (Addr'(r_outstanding) << 2) + 32'd4;
        w_pop          = !redirect_enable && !stall_in && !w_q_empty;
    end

    // Fetch PC and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (redirect_enable) r_fetch_pc <= w_redirect_pc;
            else if (w_accept)   r_fetch_pc <= r_fetch_pc + 32'd4;
            r_outstanding <= r_outstanding + OutW'(w_accept) - OutW'(imem_resp_valid);
            // Every request still in flight after this cycle belongs to the old path.
            if (redirect_enable)
                r_discard <= r_outstanding - OutW'(imem_resp_valid);
            else if (imem_resp_valid && w_drop)
                r_discard <= r_discard - OutW'(1);
        end
    end

    // Registered decode interface: redirect, then stall, then pop, else bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (redirect_enable) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (stall_in) begin
            r_instr <= r_instr;
        end else if (!w_q_empty) begin
            r_instr <= w_head.instr;
            r_pc    <= w_head.pc;
            r_valid <= 1'b1;
        end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_enable),
        .o_head      (w_head),
        .o_count     (w_q_count),
        .o_empty     (w_q_empty),
        .o_full      (w_q_full)
    );

    assign instruction_out = r_instr;
    assign pc_out          = r_pc;
    assign valid_out       = r_valid;

endmodule

// File: tb/tb_stage_1_fetch.sv
// Randomized bench for stage_1_fetch against a transaction-level reference model.
module tb_stage_1_fetch;
    import stage_1_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QD       = 2;
    localparam int          MO       = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_enable;
    logic [31:0] redirect_address;
    logic        stall_in;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        valid_out;

    always #5 clk = ~clk;

    stage_1_fetch #(
        .RESET_PC        (RESET_PC),
        .QUEUE_DEPTH     (QD),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .redirect_enable  (redirect_enable),
        .redirect_address (redirect_address),
        .stall_in         (stall_in),
        .instruction_out  (instruction_out),
        .pc_out           (pc_out),
        .valid_out        (valid_out)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Memory model: in-order requests awaiting a response, tagged by path epoch.
    logic [31:0] pend_addr [$];
    int          pend_epoch[$];

    // Reference model state.
    logic [31:0] exp_fetch_pc, exp_out_pc, prev_instr, prev_pc;
    logic        prev_valid, prev_redirect, prev_stall, exp_pop;
    int          live_q, epoch, cyc;
    bit          phase1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend_addr.delete();
        pend_epoch.delete();
        exp_fetch_pc  = RESET_PC;
        exp_out_pc    = RESET_PC + 32'd4;
        prev_instr    = NOP_INSTR;
        prev_pc       = '0;
        prev_valid    = 1'b0;
        prev_redirect = 1'b0;
        prev_stall    = 1'b0;
        exp_pop       = 1'b0;
        live_q        = 0;
        epoch         = 0;
        cyc           = 0;
    endtask

    // Decode-side checks for the outputs registered at the last edge.
    task automatic check_outputs();
        if (phase1 && cyc == 3) begin
            check_eq("first_valid", valid_out, 1);
            check_eq("first_pc", pc_out, RESET_PC + 32'd4);
        end
        if (prev_redirect) begin
            check_eq("redir_valid", valid_out, 0);
            check_eq("redir_instr", instruction_out, NOP_INSTR);
            check_eq("redir_pc", pc_out, prev_pc);
        end else if (prev_stall) begin
            check_eq("stall_valid", valid_out, prev_valid);
            check_eq("stall_instr", instruction_out, prev_instr);
            check_eq("stall_pc", pc_out, prev_pc);
        end else begin
            check_eq("pop_valid", valid_out, exp_pop);
            if (valid_out && exp_pop) begin
                check_eq("out_pc", pc_out, exp_out_pc);
                check_eq("out_instr", instruction_out, mem_word(pc_out - 32'd4));
                exp_out_pc = exp_out_pc + 32'd4;
            end else if (!valid_out) begin
                check_eq("bubble_instr", instruction_out, NOP_INSTR);
                check_eq("bubble_pc", pc_out, prev_pc);
            end
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input logic rdr, input logic [31:0] tgt, input logic stl,
                        input logic rdy, input int resp_pct);
        logic resp, acc, live_resp, pop_now, exp_req;
        redirect_enable  = rdr;
        redirect_address = tgt;
        stall_in         = stl;
        imem_req_ready   = rdy;
        resp             = (pend_addr.size() > 0) && ($urandom_range(99) < resp_pct);
        imem_resp_valid  = resp;
        imem_resp_data   = resp ? mem_word(pend_addr[0]) : $urandom;
        #1;
        exp_req = !rdr && (pend_addr.size() + live_q < QD) && (pend_addr.size() < MO);
        check_eq("req_valid", imem_req_valid, exp_req);
        if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_fetch_pc);
        check_outputs();

        acc       = imem_req_valid && rdy;
        live_resp = 1'b0;
        if (resp) begin
            live_resp = (pend_epoch[0] == epoch) && !rdr;
            void'(pend_addr.pop_front());
            void'(pend_epoch.pop_front());
        end
        if (acc) begin
            pend_addr.push_back(imem_req_addr);
            pend_epoch.push_back(epoch);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        pop_now = !rdr && !stl && (live_q > 0);
        if (rdr) begin
            exp_fetch_pc = tgt & 32'hFFFF_FFFC;
            exp_out_pc   = exp_fetch_pc + 32'd4;
            live_q       = 0;
            epoch++;
        end else begin
            live_q = live_q - int'(pop_now) + int'(live_resp);
        end
        exp_pop       = pop_now;
        prev_redirect = rdr;
        prev_stall    = stl;
        prev_instr    = instruction_out;
        prev_pc       = pc_out;
        prev_valid    = valid_out;
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_instr"}, instruction_out, NOP_INSTR);
        check_eq({tag, "_pc"}, pc_out, 0);
        check_eq({tag, "_valid"}, valid_out, 0);
        check_eq({tag, "_req"}, imem_req_valid, 0);
    endtask

    initial begin
        rst              = 1'b1;
        imem_req_ready   = 1'b0;
        imem_resp_valid  = 1'b0;
        imem_resp_data   = '0;
        redirect_enable  = 1'b0;
        redirect_address = '0;
        stall_in         = 1'b0;
        phase1           = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Streaming with an always-ready, single-cycle memory.
        rst    = 1'b0;
        phase1 = 1'b1;
        repeat (12) tick(0, 0, 0, 1, 100);
        phase1 = 1'b0;

        // Decode stall for three cycles.
        repeat (3) tick(0, 0, 1, 1, 100);
        repeat (6) tick(0, 0, 0, 1, 100);

        // Let two requests pile up unanswered, then redirect over them.
        repeat (4) tick(0, 0, 0, 1, 0);
        tick(1, 32'h0000_0100, 0, 1, 0);
        for (int i = 0; i < 20 && !valid_out; i++) tick(0, 0, 0, 1, 100);
        check_eq("redir_arrive", valid_out, 1);
        check_eq("redir_first_pc", pc_out, 32'h0000_0104);
        repeat (4) tick(0, 0, 0, 1, 100);

        // Redirect and stall together.
        tick(1, 32'h0000_0040, 1, 1, 50);
        repeat (8) tick(0, 0, 0, 1, 100);

        // Memory not ready for five cycles.
        repeat (5) tick(0, 0, 0, 0, 100);
        repeat (5) tick(0, 0, 0, 1, 100);

        // Address wrap and unaligned redirect target.
        tick(1, 32'hFFFF_FFFC, 0, 1, 100);
        repeat (8) tick(0, 0, 0, 1, 100);
        tick(1, 32'h0000_0203, 0, 1, 100);
        repeat (8) tick(0, 0, 0, 1, 100);

        // Random traffic.
        repeat (3000) tick($urandom_range(99) < 5, $urandom, $urandom_range(99) < 20,
                           $urandom_range(99) < 70, $urandom_range(10, 90));

        // Reset in the middle of streaming.
        repeat (3) tick(0, 0, 0, 1, 100);
        rst             = 1'b1;
        redirect_enable = 1'b0;
        stall_in        = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) tick(0, 0, 0, 1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
